// File: rtl/div_pkg.sv
// Shared types, default width and helpers for the sequential signed divider.
// Latency: not applicable (declarations only).
// Backpressure: not applicable (declarations only).
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        FIX
    } state_e;

    localparam int DEF_W = 16;

    // Unsigned magnitude of a two's-complement value occupying the low 'width' bits.
    // The most-negative value maps to 2^(width-1); it is not treated as an overflow.
    function automatic logic [63:0] abs_u(input logic [63:0] value, input int unsigned width);
        logic [63:0] mask;
        logic [63:0] v;
        logic [63:0] sgn;
        mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        v    = value & mask;
        sgn  = v >> (width - 1);
        if (sgn[0]) begin
            return (~v + 64'd1) & mask;
        end
        return v;
    endfunction

endpackage

// File: rtl/signed_divider_if.sv
// Request/result bundle between a divider client and the divider.
// Latency: not applicable (wiring only).
// Backpressure: start is sampled only while busy is low.
interface signed_divider_if #(
    parameter int W = div_pkg::DEF_W
);
    logic             start;
    logic [2*W-1:0]   x;
    logic [W-1:0]     y;
    logic [W-1:0]     q;
    logic [W-1:0]     r;
    logic             busy;
    logic             done;
    logic             dbz;
    logic             ovf;

    modport master (
        output start, x, y,
        input  q, r, busy, done, dbz, ovf
    );

    modport slave (
        input  start, x, y,
        output q, r, busy, done, dbz, ovf
    );
endinterface

// File: rtl/div_step.sv
// One restoring-division iteration on the combined remainder/quotient register.
// Latency: combinational.
// Backpressure: none.
module div_step #(
    parameter int W = div_pkg::DEF_W
) (
    input  logic [2*W-1:0] rq,
    input  logic [W-1:0]   ya,
    output logic [2*W-1:0] rq_nxt
);
    localparam int W2 = 2 * W;

    logic [W2:0]   sh;
    logic [W:0]    upper;
    logic [W-1:0]  trial;
    logic          ge;

    // Shift left, subtract the divisor from the top W+1 bits and keep the result if it did not borrow.
    // The remainder part is always below |y|, so an accepted trial always fits in W bits.
    always_comb begin
        sh     = {rq, 1'b0};
        upper  = sh[W2:W];
        ge     = (upper >= {1'b0, ya});
        trial  = W'(upper - {1'b0, ya});
        rq_nxt = sh[W2-1:0];
        if (ge) begin
            rq_nxt = {trial, sh[W-1:1], 1'b1};
        end
    end
endmodule

// File: rtl/signed_divider.sv
// Sequential signed divider: 2W-bit dividend / W-bit divisor, truncated quotient and remainder.
// Latency: done W+1 cycles after the start edge; divide-by-zero and overflow complete in 1 cycle.
// Backpressure: start is ignored while busy; q/r/flags hold until the next completion.
module signed_divider
    import div_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int CNT_W = $clog2(W) + 1
) (
    input  logic            clk,
    input  logic            rst,
    signed_divider_if.slave bus
);
    localparam int W2 = 2 * W;

    state_e            state;
    logic [W2-1:0]     rq;
    logic [W-1:0]      ya;
    logic              sx;
    logic              sy;
    logic [CNT_W-1:0]  cnt;

    logic [W-1:0]      q_reg;
    logic [W-1:0]      r_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              dbz_reg;
    logic              ovf_reg;

    logic [W2-1:0]     x_abs;
    logic [W-1:0]      y_abs;
    logic [W2-1:0]     rq_nxt;

    logic [W-1:0]      q_mag;
    logic [W-1:0]      r_mag;
    logic              q_neg;
    logic              range_ok;
    logic [W-1:0]      q_fix;
    logic [W-1:0]      r_fix;

    div_step #(.W(W)) u_step (
        .rq     (rq),
        .ya     (ya),
        .rq_nxt (rq_nxt)
    );

    // Operand magnitudes, evaluated on the live request so the early checks need no extra cycle.
    always_comb begin
        x_abs = W2'(abs_u(64'(bus.x), W2));
        y_abs = W'(abs_u(64'(bus.y), W));
    end

    // Sign fix-up: quotient takes sx^sy, remainder takes the dividend sign (truncation toward zero).
    // A negative quotient may reach 2^(W-1); a positive one must stay below it.
    always_comb begin
        q_mag    = rq[W-1:0];
        r_mag    = rq[W2-1:W];
        q_neg    = sx ^ sy;
        range_ok = !q_mag[W-1] || (q_neg && (q_mag == {1'b1, {(W-1){1'b0}}}));
        q_fix    = q_neg ? (~q_mag + W'(1)) : q_mag;
        r_fix    = sx ? (~r_mag + W'(1)) : r_mag;
    end

    // Control FSM with all outputs registered; done defaults low so it can only pulse for one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rq       <= '0;
            ya       <= '0;
            sx       <= 1'b0;
            sy       <= 1'b0;
            cnt      <= '0;
            q_reg    <= '0;
            r_reg    <= '0;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
            dbz_reg  <= 1'b0;
            ovf_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.y == '0) begin
                            q_reg    <= '1;
                            r_reg    <= bus.x[W-1:0];
                            dbz_reg  <= 1'b1;
                            ovf_reg  <= 1'b0;
                            done_reg <= 1'b1;
                        end else if (x_abs[W2-1:W] >= y_abs) begin
                            // Unsigned quotient would need more than W bits.
                            q_reg    <= '0;
                            r_reg    <= '0;
                            dbz_reg  <= 1'b0;
                            ovf_reg  <= 1'b1;
                            done_reg <= 1'b1;
                        end else begin
                            rq       <= x_abs;
                            ya       <= y_abs;
                            sx       <= bus.x[W2-1];
                            sy       <= bus.y[W-1];
                            cnt      <= '0;
                            busy_reg <= 1'b1;
                            state    <= ITER;
                        end
                    end
                end
                ITER: begin
                    rq  <= rq_nxt;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(W - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (range_ok) begin
                        q_reg   <= q_fix;
                        r_reg   <= r_fix;
                        ovf_reg <= 1'b0;
                    end else begin
                        q_reg   <= '0;
                        r_reg   <= '0;
                        ovf_reg <= 1'b1;
                    end
                    dbz_reg  <= 1'b0;
                    done_reg <= 1'b1;
                    busy_reg <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    busy_reg <= 1'b0;
                end
            endcase
        end
    end

    // Drive the interface from the registered outputs.
    always_comb begin
        bus.q    = q_reg;
        bus.r    = r_reg;
        bus.busy = busy_reg;
        bus.done = done_reg;
        bus.dbz  = dbz_reg;
        bus.ovf  = ovf_reg;
    end
endmodule

// File: tb/tb_signed_divider.sv
// Scoreboard bench for signed_divider: model results queued at issue, compared on done.
// Latency: checks W+1 cycles for iterated operations and 1 cycle for early completion.
// Backpressure: exercises ignored start while busy and start on the done cycle.
module tb_signed_divider;
    import div_pkg::*;

    localparam int W = 16;

    typedef struct packed {
        logic [15:0] q;
        logic [15:0] r;
        logic        dbz;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   t_start = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    exp_t sb[$];
    exp_t mon_e;
    logic mon_ok;

    signed_divider_if #(.W(W)) bus ();

    signed_divider #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs === exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
        end
    endtask

    // Reference: SV signed division truncates toward zero, matching the required semantics.
    function automatic exp_t model(input logic [31:0] xv, input logic [15:0] yv);
        exp_t   e;
        longint xs;
        longint ys;
        longint qq;
        longint rr;
        xs = longint'($signed(xv));
        ys = longint'($signed(yv));
        if (ys == 0) begin
            e = '{q: 16'hFFFF, r: xv[15:0], dbz: 1'b1, ovf: 1'b0};
        end else begin
            qq = xs / ys;
            rr = xs % ys;
            if (qq > 32767 || qq < -32768) begin
                e = '{q: 16'h0, r: 16'h0, dbz: 1'b0, ovf: 1'b1};
            end else begin
                e = '{q: qq[15:0], r: rr[15:0], dbz: 1'b0, ovf: 1'b0};
            end
        end
        return e;
    endfunction

    // Drive a request for one sampling edge; t_start records that edge.
    task automatic start_op(input logic [31:0] xv, input logic [15:0] yv, input bit expect_result);
        bus.x     = xv;
        bus.y     = yv;
        bus.start = 1'b1;
        if (expect_result) sb.push_back(model(xv, yv));
        @(posedge clk);
        #1;
        t_start   = cyc;
        bus.start = 1'b0;
    endtask

    // Wait (bounded) for done; check latency and busy-cycle count unless given as negative.
    task automatic wait_done(input string tag, input int exp_lat, input int exp_busy);
        int n;
        int nb;
        bit got;
        n   = 0;
        nb  = 0;
        got = 1'b0;
        while (!got && n < 60) begin
            @(negedge clk);
            n++;
            if (bus.done) got = 1'b1;
            else if (bus.busy) nb++;
        end
        chk({tag, "_done_seen"}, 32'(got), 32'd1);
        if (got && exp_lat >= 0) chk({tag, "_latency"}, 32'(cyc - t_start), 32'(exp_lat));
        if (got && exp_busy >= 0) chk({tag, "_busy_cycles"}, 32'(nb), 32'(exp_busy));
    endtask

    // Scoreboard: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.done) begin
            mon_ok = (sb.size() > 0);
            chk("done_with_pending", 32'(mon_ok), 32'd1);
            if (mon_ok) begin
                mon_e = sb.pop_front();
                chk("q",   32'(bus.q),   32'(mon_e.q));
                chk("r",   32'(bus.r),   32'(mon_e.r));
                chk("dbz", 32'(bus.dbz), 32'(mon_e.dbz));
                chk("ovf", 32'(bus.ovf), 32'(mon_e.ovf));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int nd;
        logic [31:0] rx;
        logic [15:0] ry;

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.x     = '0;
        bus.y     = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_q",     32'(bus.q),     32'd0);
        chk("reset_r",     32'(bus.r),     32'd0);
        chk("reset_busy",  32'(bus.busy),  32'd0);
        chk("reset_done",  32'(bus.done),  32'd0);
        chk("reset_dbz",   32'(bus.dbz),   32'd0);
        chk("reset_ovf",   32'(bus.ovf),   32'd0);
        @(posedge clk);
        #1;

        // Basic positive division.
        start_op(32'd1000, 16'd7, 1'b1);
        wait_done("pos", 17, 17);

        // Sign combinations.
        start_op(-32'sd1000, 16'sd7, 1'b1);
        wait_done("neg_x", 17, 17);
        start_op(32'sd1000, -16'sd7, 1'b1);
        wait_done("neg_y", 17, 17);
        start_op(-32'sd1000, -16'sd7, 1'b1);
        wait_done("neg_xy", 17, 17);

        // Divide by zero completes immediately.
        start_op(32'h0000_1234, 16'h0000, 1'b1);
        wait_done("dbz", 0, 0);

        // Overflow boundaries: early, most-negative fits, positive 2^15 overflows in fix-up.
        start_op(32'h0001_0000, 16'd1, 1'b1);
        wait_done("ovf_early", 0, 0);
        start_op(32'hFFFF_8000, 16'd1, 1'b1);
        wait_done("min_neg", 17, 17);
        start_op(32'h0000_8000, 16'd1, 1'b1);
        wait_done("ovf_fix", 17, 17);

        // Start while busy is ignored; then start on the done cycle.
        start_op(32'sd12345, -16'sd111, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        bus.x     = 32'd77;
        bus.y     = 16'd0;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done("ignored_start", 17, 11);
        start_op(-32'sd7, 16'sd2, 1'b1);
        wait_done("back_to_back", 17, 17);

        // Reset during the fifth iteration aborts without a done pulse.
        @(posedge clk);
        #1;
        start_op(32'd100, 16'd3, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_q",     32'(bus.q),     32'd0);
        chk("abort_r",     32'(bus.r),     32'd0);
        chk("abort_busy",  32'(bus.busy),  32'd0);
        chk("abort_done",  32'(bus.done),  32'd0);
        chk("abort_dbz",   32'(bus.dbz),   32'd0);
        chk("abort_ovf",   32'(bus.ovf),   32'd0);
        chk("abort_state", 32'(dut.state), 32'(IDLE));
        nd = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done) nd++;
        end
        chk("abort_no_done", 32'(nd), 32'd0);
        @(posedge clk);
        #1;
        start_op(32'd9, 16'd2, 1'b1);
        wait_done("after_abort", 17, 17);

        // Mixed random operands, results only.
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 0) rx = 32'($urandom_range(0, 2000000)) - 32'd1000000;
            else            rx = $urandom;
            ry = 16'($urandom_range(0, 65535));
            if (i == 5) ry = 16'hFFFF;
            start_op(rx, ry, 1'b1);
            wait_done("random", -1, -1);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/signed_divider.md
Name: signed_divider

Overview:
- Sequential signed integer divider, 2W-bit dividend by W-bit divisor; W-bit truncated quotient and W-bit remainder.
- Inverse datapath companion to the team's 16x16 Booth multiplier. Same start/busy handshake, so control FSMs drive both identically.
- Restoring division on magnitudes, one quotient bit per clock, sign fix-up in a final cycle.

Parameters:
- W, 16: divisor/quotient/remainder width; dividend is 2*W.
- CNT_W, $clog2(W)+1: iteration counter width.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  request; sampled only when busy=0
- x  in  2W  dividend, two's complement
- y  in  W  divisor, two's complement
- q  out  W  quotient, registered, held until next completion
- r  out  W  remainder, registered, held until next completion
- busy  out  1  high while an operation is in progress
- done  out  1  one-cycle pulse when q/r/flags are updated
- dbz  out  1  divide-by-zero flag for the last completed operation
- ovf  out  1  overflow flag for the last completed operation

Behaviour:
- Reset (rst=1 at an edge): state IDLE; q, r, busy, done, dbz and ovf all 0; counter 0. Applies mid-operation: the operation is aborted and no done pulse is issued.
- States: IDLE, ITER, FIX.
- IDLE, edge k with start=1:
  - If y==0: early completion. q=all ones, r=x[W-1:0], dbz=1, ovf=0, done=1; stay in IDLE, busy stays 0.
  - Else if |x|[2W-1:W] >= |y| (unsigned quotient exceeds W bits): early completion. q=0, r=0, ovf=1, dbz=0, done=1; stay in IDLE.
  - Else: latch |x| into a 2W-bit remainder/quotient shift register, latch |y| and both sign bits, clear the counter, set busy=1, enter ITER.
  - |v| is computed as unsigned; the most-negative value maps to 2^(n-1) with no overflow.
- ITER, edges k+1..k+W, one per edge:
  - Shift the register left by 1.
  - Trial = upper W+1 bits minus |y|.
  - If the trial is non-negative: the upper part becomes the trial and LSB=1; else LSB=0.
  - Increment the counter; after the W-th iteration, enter FIX.
- FIX, edge k+W+1:
  - Quotient sign = sx^sy; remainder sign = sx (truncation toward zero).
  - Signed-range check: the positive quotient magnitude must be <= 2^(W-1)-1; the negative quotient magnitude must be <= 2^(W-1).
  - Range violated: q=0, r=0, ovf=1.
  - Otherwise: write the sign-corrected q and r, ovf=0.
  - In both cases: dbz=0, done=1, busy=0, go to IDLE.
- Latency: done is asserted in the cycle after edge k+W+1 (W+1 edges after the sampling edge; 17 for W=16). Early completion: done follows edge k.
- done is high for exactly one cycle; it is 0 at every other edge.
- start while busy=1 is ignored; x and y may change freely after edge k.
- Back-to-back: start may be asserted in the same cycle done is high. It is sampled because busy=0, and a new operation begins.
- Flags always describe the last completed operation.

Decomposition:
- Shared package div_pkg:
  - state enum: IDLE, ITER, FIX
  - default W
  - function abs_u(value, width) returning unsigned magnitude
- One natural sub-module: div_step. Combinational single restoring iteration: in = partial register and |y|; out = next register.
- The FSM, counter and sign fix-up stay in signed_divider.

Test Plan:
- x=1000, y=7, start for 1 cycle -> busy for 17 cycles; done pulse with q=142, r=6, dbz=0, ovf=0.
- x=-1000 then x=1000 with y=-7 -> q=-142 (16'hFF72), r=-6 (16'hFFFA); then q=-142, r=6. Sign rules verified.
- y=0, x=32'h0000_1234 -> done on the cycle after the start edge, busy never high, q=16'hFFFF, r=16'h1234, dbz=1.
- x=32'h0001_0000, y=1 -> early ovf=1, q=0, r=0. Also x=-32768, y=1 -> q=16'h8000, ovf=0. Also x=32768, y=1 -> ovf=1 from FIX after 17 cycles.
- Start x=100, y=3; assert rst at the 5th ITER cycle -> next cycle all outputs 0, state IDLE, no done pulse. Then start x=9, y=2 -> q=4, r=1.
- Re-pulse start mid-operation (ignored, result unchanged); then assert start on the done cycle with x=-7, y=2 -> second done 17 cycles later with q=-3, r=-1.
